// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// frame header bytes, frame lengths and the nonce checksum helper.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_e;

  localparam logic [7:0] HDR_NONCE  = 8'hA5;
  localparam logic [7:0] HDR_STATUS = 8'h5A;

  localparam logic [2:0] LEN_NONCE  = 3'd6;
  localparam logic [2:0] LEN_STATUS = 3'd3;

  // XOR of the four nonce bytes, sent as the last byte of a nonce frame.
  function automatic logic [7:0] nonce_chk(input logic [31:0] n);
    return n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
// Holds one outgoing frame (up to 6 bytes). On load it builds either a nonce
// frame (header, 4 nonce bytes MSB first, checksum) or a status frame
// (header, status, status) and latches the frame length.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   load_i       build a new frame at this edge
//   sel_nonce_i  1 = nonce frame, 0 = status frame
//   nonce_i      nonce value for a nonce frame
//   status_i     status byte for a status frame
//   idx_i        byte index to read
//   byte_o       stored byte at idx_i (0 beyond the frame length)
//   len_o        length of the stored frame
module uart_frame_buf
  import uart_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        sel_nonce_i,
  input  logic [31:0] nonce_i,
  input  logic [7:0]  status_i,
  input  logic [2:0]  idx_i,
  output logic [7:0]  byte_o,
  output logic [2:0]  len_o
);

  logic [7:0] frame_q [6];
  logic [7:0] frame_d [6];
  logic [2:0] len_q, len_d;

  always_comb begin
    for (int i = 0; i < 6; i++) frame_d[i] = frame_q[i];
    len_d = len_q;
    if (load_i) begin
      if (sel_nonce_i) begin
        frame_d[0] = HDR_NONCE;
        frame_d[1] = nonce_i[31:24];
        frame_d[2] = nonce_i[23:16];
        frame_d[3] = nonce_i[15:8];
        frame_d[4] = nonce_i[7:0];
        frame_d[5] = nonce_chk(nonce_i);
        len_d      = LEN_NONCE;
      end else begin
        frame_d[0] = HDR_STATUS;
        frame_d[1] = status_i;
        frame_d[2] = status_i;  // checksum of a single byte is the byte
        frame_d[3] = 8'h00;
        frame_d[4] = 8'h00;
        frame_d[5] = 8'h00;
        len_d      = LEN_STATUS;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 6; i++) frame_q[i] <= 8'h00;
      len_q <= 3'd0;
    end else begin
      for (int i = 0; i < 6; i++) frame_q[i] <= frame_d[i];
      len_q <= len_d;
    end
  end

  always_comb begin
    byte_o = 8'h00;
    if (idx_i < len_q) begin
      case (idx_i)
        3'd0:    byte_o = frame_q[0];
        3'd1:    byte_o = frame_q[1];
        3'd2:    byte_o = frame_q[2];
        3'd3:    byte_o = frame_q[3];
        3'd4:    byte_o = frame_q[4];
        3'd5:    byte_o = frame_q[5];
        default: byte_o = 8'h00;
      endcase
    end
  end

  assign len_o = len_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Arbitrates a pending nonce report and a pending status report, frames the
// chosen one and feeds it byte by byte to the UART transmitter.
//
// Ports:
//   clock, reset         system clock, asynchronous active-low reset
//   nonce_we, nonce      capture a nonce into the nonce slot
//   status_req, status   capture a status byte into the status slot
//   clear_flags          clear nonce_overrun and tx_error
//   tx_busy              transmitter is shifting a byte
//   tx_start, tx_data    one-cycle load pulse and the byte to load
//   active               scheduler is not idle
//   nonce_overrun        sticky: a pending nonce was overwritten unsent
//   tx_error             sticky: transmitter never acknowledged a start
//   dbg_state            current FSM state (uart_sched_pkg::state_e encoding)
//
// Transmitter handshake: tx_start is a single-cycle pulse, only raised while
// tx_busy is low. The transmitter acknowledges by raising tx_busy and finishes
// the byte by dropping it; tx_data is held from the pulse until that fall.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nonce_we,
  input  logic [31:0] nonce,
  input  logic        status_req,
  input  logic [7:0]  status,
  input  logic        clear_flags,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        active,
  output logic        nonce_overrun,
  output logic        tx_error,
  output logic [2:0]  dbg_state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [31:0]   nonce_slot_q, nonce_slot_d;
  logic          nonce_vld_q, nonce_vld_d;
  logic [7:0]    status_slot_q, status_slot_d;
  logic          status_vld_q, status_vld_d;

  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          active_q, active_d;
  logic          overrun_q, overrun_d;
  logic          error_q, error_d;

  logic          load;
  logic          sel_nonce;
  logic          err_set;
  logic          overrun_set;
  logic [7:0]    frame_byte;
  logic [2:0]    frame_len;
  logic [2:0]    idx_nxt;

  uart_frame_buf u_frame_buf (
    .clk_i       (clock),
    .rst_ni      (reset),
    .load_i      (load),
    .sel_nonce_i (sel_nonce),
    .nonce_i     (nonce_slot_q),
    .status_i    (status_slot_q),
    .idx_i       (idx_d),
    .byte_o      (frame_byte),
    .len_o       (frame_len)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      gap_q         <= '0;
      tmo_q         <= '0;
      nonce_slot_q  <= 32'h0;
      nonce_vld_q   <= 1'b0;
      status_slot_q <= 8'h00;
      status_vld_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      active_q      <= 1'b0;
      overrun_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      nonce_slot_q  <= nonce_slot_d;
      nonce_vld_q   <= nonce_vld_d;
      status_slot_q <= status_slot_d;
      status_vld_q  <= status_vld_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      active_q      <= active_d;
      overrun_q     <= overrun_d;
      error_q       <= error_d;
    end
  end

  // Next-state logic and counters.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    load      = 1'b0;
    sel_nonce = 1'b0;
    err_set   = 1'b0;
    idx_nxt   = idx_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (nonce_vld_q || status_vld_q) begin
          load      = 1'b1;
          sel_nonce = nonce_vld_q;  // nonce has fixed priority
          idx_d     = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        // Stay here until the pulse has actually gone out.
        if (tx_start_q) begin
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_nxt < frame_len) begin
            idx_d   = idx_nxt;
            state_d = START;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values.
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (state_d == START && !tx_busy) begin
      tx_start_d = 1'b1;
      // On the IDLE->START edge the frame buffer is being loaded, so the
      // header is taken directly; byte 0 of every frame is its header.
      if (state_q == IDLE) begin
        tx_data_d = sel_nonce ? HDR_NONCE : HDR_STATUS;
      end else begin
        tx_data_d = frame_byte;
      end
    end
    active_d = (state_d != IDLE);
  end

  // Pending slots and sticky flags. A write in the same cycle as a consume
  // keeps the slot valid with the new value and is not an overrun.
  always_comb begin
    nonce_slot_d  = nonce_slot_q;
    nonce_vld_d   = nonce_vld_q;
    status_slot_d = status_slot_q;
    status_vld_d  = status_vld_q;
    overrun_set   = 1'b0;

    if (nonce_we) begin
      nonce_slot_d = nonce;
      nonce_vld_d  = 1'b1;
      overrun_set  = nonce_vld_q && !(load && sel_nonce);
    end else if (load && sel_nonce) begin
      nonce_vld_d = 1'b0;
    end

    if (status_req) begin
      status_slot_d = status;
      status_vld_d  = 1'b1;
    end else if (load && !sel_nonce) begin
      status_vld_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (overrun_set)      overrun_d = 1'b1;
    else if (clear_flags) overrun_d = 1'b0;

    error_d = error_q;
    if (err_set)          error_d = 1'b1;
    else if (clear_flags) error_d = 1'b0;
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign active        = active_q;
  assign nonce_overrun = overrun_q;
  assign tx_error      = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int GAP_CYCLES   = 16;
  localparam int BUSY_TIMEOUT = 8;
  localparam int BUSY_LEN     = 10;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd4;

  logic        clock;
  logic        reset;
  logic        nonce_we;
  logic [31:0] nonce;
  logic        status_req;
  logic [7:0]  status;
  logic        clear_flags;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        active;
  logic        nonce_overrun;
  logic        tx_error;
  logic [2:0]  dbg_state;

  logic        xmit_en;
  logic [7:0]  busy_left;
  logic        prev_busy = 1'b0;

  logic [7:0]  exp_q[$];
  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fall_cyc = 0;
  int          hdr_gap  = -1;
  int          n_starts = 0;

  uart_tx_scheduler #(
    .GAP_CYCLES   (GAP_CYCLES),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .nonce_we      (nonce_we),
    .nonce         (nonce),
    .status_req    (status_req),
    .status        (status),
    .clear_flags   (clear_flags),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .active        (active),
    .nonce_overrun (nonce_overrun),
    .tx_error      (tx_error),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // ---------------- transmitter model ----------------
  // Busy for BUSY_LEN cycles after each accepted start; ignores starts when
  // xmit_en is low.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_busy   <= 1'b0;
      busy_left <= 8'd0;
    end else if (tx_start && xmit_en) begin
      tx_busy   <= 1'b1;
      busy_left <= 8'(BUSY_LEN - 1);
    end else if (busy_left != 8'd0) begin
      busy_left <= busy_left - 8'd1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_nonce_frame(input logic [31:0] n);
    exp_q.push_back(8'hA5);
    exp_q.push_back(n[31:24]);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      if (tx_start) begin
        logic [7:0] e;
        n_starts++;
        check("busy_low_at_start", {31'd0, tx_busy}, 32'd0);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_start: observed=tx_data %0h expected=no start", tx_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e});
          if (e == 8'h5A) hdr_gap = cyc - fall_cyc;
        end
      end
    end
    prev_busy = tx_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_nonce(input logic [31:0] v);
    nonce    = v;
    nonce_we = 1'b1;
    @(posedge clock);
    #1 nonce_we = 1'b0;
  endtask

  task automatic pulse_status(input logic [7:0] v);
    status     = v;
    status_req = 1'b1;
    @(posedge clock);
    #1 status_req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clock);
    #1 clear_flags = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(exp_q.size() == 0 && active === 1'b0) && k < 3000);
    n_cmp++;
    assert (exp_q.size() == 0 && active === 1'b0) else begin
      n_fail++;
      $error("FAIL %s: observed=pending %0d active %b expected=pending 0 active 0",
             tag, exp_q.size(), active);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int k;
    int wb;
    int base;
    logic [7:0] seq1 [6];
    logic [7:0] seq2 [9];

    reset = 1'b0; nonce_we = 1'b0; nonce = 32'h0; status_req = 1'b0;
    status = 8'h00; clear_flags = 1'b0; xmit_en = 1'b1;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_overrun", {31'd0, nonce_overrun}, 32'd0);
    check("rst_tx_error", {31'd0, tx_error}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // T1: nonce 0x12345678, latency and gap timing
    seq1 = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    foreach (seq1[i]) exp_q.push_back(seq1[i]);
    pulse_nonce(32'h12345678);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!tx_start && lat < 20);
    check("t1_start_latency", lat, 2);
    wait_done("t1_done");
    check("t1_active_fall", cyc - fall_cyc, GAP_CYCLES + 1);

    // T2: simultaneous status and nonce, nonce wins
    seq2 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'h5A, 8'h3C, 8'h3C};
    foreach (seq2[i]) exp_q.push_back(seq2[i]);
    nonce = 32'hDEADBEEF; status = 8'h3C;
    nonce_we = 1'b1; status_req = 1'b1;
    @(posedge clock);
    #1 nonce_we = 1'b0; status_req = 1'b0;
    wait_done("t2_done");
    check("t2_frame_gap", hdr_gap, GAP_CYCLES + 2);

    // T3: overrun during an active frame, then clear
    push_nonce_frame(32'hCAFEF00D);
    pulse_nonce(32'hCAFEF00D);
    repeat (6) @(negedge clock);
    pulse_nonce(32'h1);
    @(negedge clock);
    check("t3_first_write_no_overrun", {31'd0, nonce_overrun}, 32'd0);
    repeat (2) @(negedge clock);
    pulse_nonce(32'h2);
    @(negedge clock);
    check("t3_overrun_set", {31'd0, nonce_overrun}, 32'd1);
    push_nonce_frame(32'h2);
    wait_done("t3_done");
    check("t3_overrun_sticky", {31'd0, nonce_overrun}, 32'd1);
    pulse_clear();
    @(negedge clock);
    check("t3_overrun_cleared", {31'd0, nonce_overrun}, 32'd0);

    // T3b: overrun and clear in the same cycle, set wins
    push_nonce_frame(32'h000000FF);
    pulse_nonce(32'h000000FF);
    repeat (6) @(negedge clock);
    pulse_nonce(32'h11);
    repeat (2) @(negedge clock);
    nonce = 32'h22; nonce_we = 1'b1; clear_flags = 1'b1;
    @(posedge clock);
    #1 nonce_we = 1'b0; clear_flags = 1'b0;
    @(negedge clock);
    check("t3b_set_wins", {31'd0, nonce_overrun}, 32'd1);
    push_nonce_frame(32'h22);
    wait_done("t3b_done");

    // T4: transmitter never acknowledges -> timeout
    pulse_clear();
    @(negedge clock);
    check("t4_flags_clear", {31'd0, nonce_overrun}, 32'd0);
    xmit_en = 1'b0;
    exp_q.push_back(8'hA5);
    pulse_nonce(32'h00000055);
    wb = 0; k = 0;
    while (tx_error !== 1'b1 && k < 60) begin
      @(negedge clock);
      k++;
      if (dbg_state === ST_WAIT_BUSY) wb++;
    end
    check("t4_tx_error", {31'd0, tx_error}, 32'd1);
    check("t4_wait_busy_cycles", wb, BUSY_TIMEOUT);
    check("t4_state_gap", {29'd0, dbg_state}, {29'd0, ST_GAP});
    wait_done("t4_idle");
    xmit_en = 1'b1;
    pulse_clear();
    @(negedge clock);
    check("t4_error_cleared", {31'd0, tx_error}, 32'd0);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h81); exp_q.push_back(8'h81);
    pulse_status(8'h81);
    wait_done("t4_recover");
    check("t4_no_new_error", {31'd0, tx_error}, 32'd0);

    // T5: reset during byte 3 of a nonce frame
    exp_q.push_back(8'hA5); exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
    base = n_starts;
    pulse_nonce(32'h0BADF00D);
    k = 0;
    while (n_starts < base + 3 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("t5_three_bytes", n_starts - base, 3);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t5_rst_active", {31'd0, active}, 32'd0);
    check("t5_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    base = n_starts;
    repeat (60) @(negedge clock);
    check("t5_no_bytes_after_release", n_starts - base, 0);
    check("t5_active_low", {31'd0, active}, 32'd0);
    push_nonce_frame(32'h00C0FFEE);
    pulse_nonce(32'h00C0FFEE);
    wait_done("t5_new_frame");

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Byte-level transmit scheduler between the miner core and the UART transmitter. Arbitrates two report sources, a found nonce and an 8-bit status word, and frames each into a fixed byte sequence with header and XOR checksum. Drives the transmitter one byte at a time over a start/busy handshake. Sits between the nonce register logic (`nonce_we`, nonce value) and the byte-wide UART TX engine inside the UART core.

## Interface
- `GAP_CYCLES`, 16: idle clock cycles enforced between consecutive frames (≥1).
- `BUSY_TIMEOUT`, 8: cycles to wait for `tx_busy` to rise after `tx_start` before declaring error (≥2).
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset); clears all state.
- `nonce_we` in 1: capture `nonce` into pending slot this cycle.
- `nonce` in 32: winning nonce value.
- `status_req` in 1: capture `status` into pending slot this cycle.
- `status` in 8: status byte.
- `clear_flags` in 1: clears `nonce_overrun` and `tx_error`.
- `tx_busy` in 1: transmitter shifting a byte.
- `tx_start` out 1: one-cycle pulse, transmitter loads `tx_data`.
- `tx_data` out 8: byte to send; stable from `tx_start` until `tx_busy` falls.
- `active` out 1: high whenever state ≠ IDLE.
- `nonce_overrun` out 1: sticky; a pending nonce was overwritten before sending.
- `tx_error` out 1: sticky; `BUSY_TIMEOUT` expired.

## Operation
- Nonce frame, 6 bytes: 0xA5, nonce[31:24], [23:16], [15:8], [7:0], XOR of the four nonce bytes.
- Status frame, 3 bytes: 0x5A, status, status (XOR of one byte).
- Pending slots: one per source, each with a valid bit. `nonce_we` sets the nonce slot. If that slot is already valid and not being consumed this edge, overwrite it and set `nonce_overrun`. `status_req` overwrites the status slot silently.
- At frame start the chosen slot is copied into the frame buffer and its valid bit is cleared. A write in the same cycle wins: the slot stays valid with the new value, and no overrun is flagged.
- Priority: nonce over status when both are valid in IDLE. Fixed priority, non-preemptive; a frame in progress always completes.
- FSM:
  - IDLE: if any slot valid, load frame, byte index = 0, go to START.
  - START: `tx_start` = 1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy` = 1, go to WAIT_DONE. After `BUSY_TIMEOUT` cycles without it, set `tx_error` and go to GAP (frame dropped).
  - WAIT_DONE: on `tx_busy` = 0, increment the index. If index < length, go to START; otherwise go to GAP.
  - GAP: count `GAP_CYCLES`, then go to IDLE.
- `tx_start` is issued only when `tx_busy` = 0. If START is entered with `tx_busy` high, hold in START with `tx_start` = 0 until it drops.
- `clear_flags` clears both sticky flags. A set event in the same cycle wins.

## Timing
- Reset values: `tx_start` 0, `tx_data` 0x00, `active` 0, `nonce_overrun` 0, `tx_error` 0, both slots invalid, state IDLE.
- All outputs are registered.
- Latency: `nonce_we` high in cycle N, IDLE in N+1, `tx_start` high in cycle N+2 (gap already elapsed).
- Per byte: START takes 1 cycle, plus the transmitter's busy time, plus 1 cycle after `tx_busy` falls before the next START.
- Frame-to-frame: at least `GAP_CYCLES` + 1 cycles from the last `tx_busy` fall to the next `tx_start`.
- Reset asserted mid-frame: the frame is aborted immediately, pending slots are lost, and `tx_start` is low. The transmitter's current byte is not tracked.
- Timeout counter, gap counter and byte index all reset to 0 on state entry. No wrap; each counter saturates at its terminal value.

## Structure
- Package `uart_sched_pkg`:
  - state enum: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP;
  - header constants `HDR_NONCE` = 8'hA5 and `HDR_STATUS` = 8'h5A;
  - frame lengths `LEN_NONCE` = 6 and `LEN_STATUS` = 3.
- One sub-module, `uart_frame_buf`. It loads nonce or status, computes the checksum on load, holds the 6-byte frame, and outputs the byte at the current index plus the frame length.
- The FSM, pending slots, counters and flags stay in the top module.

## Test plan
- Nonce 0x12345678, transmitter model busy for 10 cycles per byte → `tx_data` sequence A5,12,34,56,78,08; `tx_start` first seen 2 cycles after `nonce_we`; `active` falls `GAP_CYCLES` + 1 cycles after the last busy fall.
- `status_req` with 0x3C and `nonce_we` with 0xDEADBEEF in the same cycle → nonce frame A5,DE,AD,BE,EF,22 first, then after the gap 5A,3C,3C.
- Two `nonce_we` pulses (0x1, then 0x2) during an active nonce frame → next frame carries 0x00000002 and `nonce_overrun` = 1. `clear_flags` → 0.
- Transmitter never raises `tx_busy` → `tx_error` = 1 after 8 cycles in WAIT_BUSY, then GAP → IDLE; a later frame sends normally.
- Reset pulled low during byte 3 of a nonce frame → `tx_start` stays 0, `active` = 0, no bytes after release until a new `nonce_we`.
